// File: rtl/guess_game_param.sv
// Parametrised number-guessing game: free-running secret counter, one check per
// button press, registered comparison LEDs, try counter and win/lose status.
module guess_game_param #(
    parameter int WIDTH     = 8,
    parameter int RANGE_MAX = 2**WIDTH-1,
    parameter int MAX_TRIES = 7,
    parameter int TRY_W     = $clog2(MAX_TRIES+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enter,
    input  logic [WIDTH-1:0] i_guess,
    output logic [WIDTH-1:0] o_actual,
    output logic             o_over,
    output logic             o_under,
    output logic             o_equal,
    output logic [TRY_W-1:0] o_tries,
    output logic             o_win,
    output logic             o_lose
);

    typedef enum logic [2:0] {
        S_GEN,
        S_REL,
        S_CHECK,
        S_WAIT,
        S_END,
        S_NEWREL
    } state_e;

    localparam logic [WIDTH-1:0] ACTUAL_MAX = WIDTH'(RANGE_MAX);
    localparam logic [TRY_W-1:0] TRIES_INIT = TRY_W'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] actual_q, actual_d;
    logic             over_q, over_d;
    logic             under_q, under_d;
    logic             equal_q, equal_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        actual_d = actual_q;
        over_d   = over_q;
        under_d  = under_q;
        equal_d  = equal_q;
        tries_d  = tries_q;
        win_d    = win_q;
        lose_d   = lose_q;

        unique case (state_q)
            S_GEN: begin
                if (i_enter) begin
                    state_d = S_REL;
                end else begin
                    actual_d = (actual_q == ACTUAL_MAX) ? '0 : actual_q + WIDTH'(1);
                end
            end
            S_REL: begin
                if (!i_enter) state_d = S_CHECK;
            end
            S_CHECK: begin
                over_d  = (i_guess > actual_q);
                under_d = (i_guess < actual_q);
                equal_d = (i_guess == actual_q);
                if (tries_q != '0) tries_d = tries_q - TRY_W'(1);
                // A match on the last try still counts as a win.
                if (i_guess == actual_q) begin
                    state_d = S_END;
                    win_d   = 1'b1;
                end else if (tries_q <= TRY_W'(1)) begin
                    state_d = S_END;
                    lose_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_enter) state_d = S_REL;
            end
            S_END: begin
                if (i_enter) state_d = S_NEWREL;
            end
            S_NEWREL: begin
                // The secret is left alone so the next game starts from an unpredictable value.
                if (!i_enter) begin
                    state_d = S_GEN;
                    over_d  = 1'b0;
                    under_d = 1'b0;
                    equal_d = 1'b0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    tries_d = TRIES_INIT;
                end
            end
            default: state_d = S_GEN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_GEN;
            actual_q <= '0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            equal_q  <= 1'b0;
            tries_q  <= TRIES_INIT;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            actual_q <= actual_d;
            over_q   <= over_d;
            under_q  <= under_d;
            equal_q  <= equal_d;
            tries_q  <= tries_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
        end
    end

    assign o_actual = actual_q;
    assign o_over   = over_q;
    assign o_under  = under_q;
    assign o_equal  = equal_q;
    assign o_tries  = tries_q;
    assign o_win    = win_q;
    assign o_lose   = lose_q;

endmodule

// File: tb/tb_guess_game_param.sv
// Bench for guess_game_param: directed vector table, wrap/held-button and async
// reset sequences, then random games checked against a transaction-level model.
module tb_guess_game_param;

    localparam int RANGE_A = 255;
    localparam int TRIES_A = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       enter_a = 1'b0;
    logic [7:0] guess_a = 8'd0;
    logic [7:0] a_actual;
    logic       a_over, a_under, a_equal, a_win, a_lose;
    logic [2:0] a_tries;

    logic       enter_b = 1'b0;
    logic [7:0] guess_b = 8'd0;
    logic [7:0] b_actual;
    logic       b_over, b_under, b_equal, b_win, b_lose;
    logic [2:0] b_tries;

    int tests  = 0;
    int failed = 0;

    // Game-level model of dut_a.
    int  m_secret;
    int  m_tries;
    bit  m_over, m_under, m_equal, m_win, m_lose;
    bit  m_in_gen;
    bit  m_ended;

    typedef struct {
        logic [7:0] guess;
        int         hold;
        logic       over;
        logic       under;
        logic       equal;
        logic [2:0] tries;
        logic       win;
        logic       lose;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    guess_game_param dut_a (
        .clk(clk), .reset(reset), .i_enter(enter_a), .i_guess(guess_a),
        .o_actual(a_actual), .o_over(a_over), .o_under(a_under), .o_equal(a_equal),
        .o_tries(a_tries), .o_win(a_win), .o_lose(a_lose)
    );

    guess_game_param #(.RANGE_MAX(9)) dut_b (
        .clk(clk), .reset(reset), .i_enter(enter_b), .i_guess(guess_b),
        .o_actual(b_actual), .o_over(b_over), .o_under(b_under), .o_equal(b_equal),
        .o_tries(b_tries), .o_win(b_win), .o_lose(b_lose)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_secret = 0;
        m_tries  = TRIES_A;
        m_over   = 0;
        m_under  = 0;
        m_equal  = 0;
        m_win    = 0;
        m_lose   = 0;
        m_in_gen = 1;
        m_ended  = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_actual"}, int'(a_actual), m_secret);
        check({tag, "_over"},   int'(a_over),   int'(m_over));
        check({tag, "_under"},  int'(a_under),  int'(m_under));
        check({tag, "_equal"},  int'(a_equal),  int'(m_equal));
        check({tag, "_tries"},  int'(a_tries),  m_tries);
        check({tag, "_win"},    int'(a_win),    int'(m_win));
        check({tag, "_lose"},   int'(a_lose),   int'(m_lose));
    endtask

    task automatic edge_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Idle cycles with the button up; the secret only moves while a game is being generated.
    task automatic tick(input int n);
        edge_n(n);
        if (m_in_gen) m_secret = (m_secret + n) % (RANGE_A + 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        enter_a = 1'b0;
        reset   = 1'b1;
        #1;
        model_reset();
        check_model("async_reset");
        #2;
        reset = 1'b0;
    endtask

    // One press/release: a guess during a game, or a restart after the game has ended.
    task automatic press(input logic [7:0] g, input int hold);
        guess_a = g;
        enter_a = 1'b1;
        for (int i = 0; i < hold; i++) begin
            edge_n(1);
            m_in_gen = 0;
            check("hold_actual", int'(a_actual), m_secret);
        end
        enter_a = 1'b0;
        if (m_ended) begin
            edge_n(1);
            m_over   = 0;
            m_under  = 0;
            m_equal  = 0;
            m_win    = 0;
            m_lose   = 0;
            m_tries  = TRIES_A;
            m_ended  = 0;
            m_in_gen = 1;
            check_model("restart");
        end else begin
            edge_n(1);
            check_model("check_cycle");
            edge_n(1);
            m_over  = (int'(g) > m_secret);
            m_under = (int'(g) < m_secret);
            m_equal = (int'(g) == m_secret);
            m_tries = m_tries - 1;
            if (m_equal) begin
                m_win   = 1;
                m_ended = 1;
            end else if (m_tries == 0) begin
                m_lose  = 1;
                m_ended = 1;
            end
            check_model("result");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'd5,   3, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0};
        vecs[1]  = '{8'd200, 1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[2]  = '{8'd10,  2, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[3]  = '{8'd99,  4, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0};
        vecs[4]  = '{8'd3,   1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0};
        vecs[5]  = '{8'd50,  2, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[6]  = '{8'd0,   1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        vecs[7]  = '{8'd255, 3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[8]  = '{8'd9,   1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[9]  = '{8'd11,  2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[10] = '{8'd200, 1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[11] = '{8'd42,  4, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0};

        // Reset asserted between edges; outputs must follow without a clock.
        #1;
        reset = 1'b1;
        #2;
        model_reset();
        check_model("reset_init");
        check("reset_b_tries", int'(b_tries), 7);
        #9;
        reset = 1'b0;

        // Wrap with RANGE_MAX=9: 12 increments from 0 land on 2.
        edge_n(12);
        check("wrap_actual", int'(b_actual), 2);
        guess_b = 8'd5;
        enter_b = 1'b1;
        edge_n(20);
        check("held_actual", int'(b_actual), 2);
        check("held_tries", int'(b_tries), 7);
        enter_b = 1'b0;
        edge_n(2);
        check("held_one_check_tries", int'(b_tries), 6);
        check("held_over", int'(b_over), 1);
        check("held_under", int'(b_under), 0);
        edge_n(5);
        check("held_tries_stable", int'(b_tries), 6);

        // Directed games with secret 10.
        do_reset();
        tick(10);
        check("counter_start", int'(a_actual), 10);
        for (int i = 0; i < 12; i++) begin
            press(vecs[i].guess, vecs[i].hold);
            check($sformatf("v%0d_over", i),  int'(a_over),  int'(vecs[i].over));
            check($sformatf("v%0d_under", i), int'(a_under), int'(vecs[i].under));
            check($sformatf("v%0d_equal", i), int'(a_equal), int'(vecs[i].equal));
            check($sformatf("v%0d_tries", i), int'(a_tries), int'(vecs[i].tries));
            check($sformatf("v%0d_win", i),   int'(a_win),   int'(vecs[i].win));
            check($sformatf("v%0d_lose", i),  int'(a_lose),  int'(vecs[i].lose));
            if (i == 2) begin
                guess_a = 8'd77;
                tick(5);
                check("post_win_equal", int'(a_equal), 1);
                check("post_win_tries", int'(a_tries), 4);
                check_model("post_win_idle");
            end
        end
        tick(3);
        check("restart_resumes_count", int'(a_actual), 13);

        // Mid-game async reset from S_WAIT with three tries left.
        repeat (4) press(8'd255, 1);
        check("pre_reset_tries", int'(a_tries), 3);
        check("pre_reset_over", int'(a_over), 1);
        do_reset();
        tick(4);
        check("post_reset_count", int'(a_actual), 4);

        // Random games against the model.
        for (int n = 0; n < 300; n++) begin
            tick($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                press(8'(m_secret), $urandom_range(1, 4));
            end else begin
                press(8'($urandom_range(0, 255)), $urandom_range(1, 4));
            end
        end
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
